// File: rtl/riscv_mem_pkg.sv
// riscv_mem_pkg
// Shared definitions for the MEM-stage load/store unit of the RV32I pipeline.
// Contents:
//   - funct3 access-size encodings (B, H, W, BU, HU)
//   - access-size enum and a decoder that folds 011/110/111 into a word access
//   - LSU state enum (IDLE / BUSY / DONE)
//   - byte-enable width of the 32-bit data bus
// No ports; imported by the interface, the top and the load extender.
package riscv_mem_pkg;

  // One enable bit per byte lane of the 32-bit data bus.
  localparam int unsigned BE_W = 4;

  // funct3 encodings for loads and stores.
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } size_e;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } lsu_state_e;

  // Reserved encodings (011, 110, 111) fall through to a full-word access.
  function automatic size_e decode_size(input logic [2:0] funct3);
    size_e sz;
    case (funct3)
      F3_B, F3_BU: sz = SZ_BYTE;
      F3_H, F3_HU: sz = SZ_HALF;
      F3_W:        sz = SZ_WORD;
      default:     sz = SZ_WORD;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// mem_stage_lsu_if
// Single-outstanding req/ack data-memory bus between the MEM-stage LSU and
// data memory.
// Signals:
//   dmem_req    request, held until ack
//   dmem_we     1 = write, 0 = read
//   dmem_addr   word-aligned byte address
//   dmem_wdata  lane-replicated store data
//   dmem_be     byte enables
//   dmem_ack    one-cycle completion pulse from memory
//   dmem_rdata  read data, valid together with ack
// Modports: master (LSU side), slave (memory side).
interface mem_stage_lsu_if;
  import riscv_mem_pkg::*;

  logic            dmem_req;
  logic            dmem_we;
  logic [31:0]     dmem_addr;
  logic [31:0]     dmem_wdata;
  logic [BE_W-1:0] dmem_be;
  logic            dmem_ack;
  logic [31:0]     dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output dmem_ack, dmem_rdata
  );

endinterface

// File: rtl/mem_stage_lsu_load_extend.sv
// load_extend
// Purely combinational load-data formatter: picks the addressed byte or
// halfword out of the 32-bit read word and sign- or zero-extends it.
// Ports:
//   rdata_i   [31:0]  raw word returned by data memory
//   offset_i  [1:0]   byte offset of the access inside the word
//   funct3_i  [2:0]   load funct3 (size in [1:0], unsigned flag in [2])
//   data_o    [31:0]  extended load result
module load_extend
  import riscv_mem_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [7:0]  byteLane;
  logic [15:0] halfLane;

  // Lane selection first, then extension; funct3[2] marks BU/HU.
  always_comb begin
    byteLane = 8'h00;
    case (offset_i)
      2'd0:    byteLane = rdata_i[7:0];
      2'd1:    byteLane = rdata_i[15:8];
      2'd2:    byteLane = rdata_i[23:16];
      default: byteLane = rdata_i[31:24];
    endcase

    halfLane = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    data_o = rdata_i;
    case (decode_size(funct3_i))
      SZ_BYTE: data_o = funct3_i[2] ? {24'h000000, byteLane}
                                    : {{24{byteLane[7]}}, byteLane};
      SZ_HALF: data_o = funct3_i[2] ? {16'h0000, halfLane}
                                    : {{16{halfLane[15]}}, halfLane};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu
// MEM-stage load/store unit of the 5-stage RV32I pipeline. Takes one load or
// store from the EX/MEM register, issues it on a single-outstanding req/ack
// data bus, and returns the aligned, extended load result toward MEM/WB.
// The upstream pipeline is frozen through stall_out while an access is in
// flight; a one-cycle DONE state lets EX/MEM advance past the finished op.
//
// Ports:
//   clk, reset       rising-edge clock, synchronous active-high reset
//   valid_in         EX/MEM holds a load or store this cycle
//   mem_rw_in        1 = store, 0 = load
//   instruction_in   EX/MEM instruction; funct3 = [14:12]
//   alu_result_in    effective byte address
//   store_data_in    rs2 value
//   dmem             data bus (mem_stage_lsu_if.master)
//   load_data_out    extended load result (registered, held)
//   load_valid_out   one-cycle pulse when load_data_out is fresh
//   stall_out        freeze PC, IF/ID, ID/EX, EX/MEM
//   misalign_out     one-cycle pulse on a trapped misaligned access
//
// Build option LSU_MISALIGN_TRAP_EN:
//   defined   - misaligned H/W accesses skip the bus and pulse misalign_out
//   undefined - low address bits are forced to alignment; misalign_out is 0
module mem_stage_lsu
  import riscv_mem_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   valid_in,
  input  logic                   mem_rw_in,
  input  logic [31:0]            instruction_in,
  input  logic [31:0]            alu_result_in,
  input  logic [31:0]            store_data_in,
  mem_stage_lsu_if.master        dmem,
  output logic [31:0]            load_data_out,
  output logic                   load_valid_out,
  output logic                   stall_out,
  output logic                   misalign_out
);

  lsu_state_e      state_q;
  logic            req_q;
  logic            we_q;
  logic [31:0]     addr_q;
  logic [31:0]     wdata_q;
  logic [BE_W-1:0] be_q;
  logic [1:0]      offset_q;
  logic [2:0]      funct3_q;
  logic [31:0]     loadData_q;
  logic            loadValid_q;
  logic            misalign_q;

  logic [2:0]      funct3In;
  size_e           sizeIn;
  logic [31:0]     addr_d;
  logic [31:0]     wdata_d;
  logic [BE_W-1:0] be_d;
  logic [1:0]      offset_d;
  logic [31:0]     extData;
  logic            trapHit;
  logic            unusedInstrBits;

  assign funct3In = instruction_in[14:12];
  assign sizeIn   = decode_size(funct3In);
  assign addr_d   = {alu_result_in[31:2], 2'b00};

  // Only funct3 matters here; the rest of the instruction is consumed elsewhere.
  assign unusedInstrBits = ^{instruction_in[31:15], instruction_in[11:0]};

  // Build the bus beat for the incoming op. The offset is forced to the
  // natural alignment of the access size, so a misaligned half or word
  // (when not trapped) lands on the aligned lanes below it.
  always_comb begin
    offset_d = alu_result_in[1:0];
    be_d     = 4'b1111;
    wdata_d  = store_data_in;
    case (sizeIn)
      SZ_BYTE: begin
        be_d    = 4'b0001 << offset_d;
        wdata_d = {4{store_data_in[7:0]}};
      end
      SZ_HALF: begin
        offset_d = {alu_result_in[1], 1'b0};
        be_d     = 4'b0011 << offset_d;
        wdata_d  = {2{store_data_in[15:0]}};
      end
      default: begin
        offset_d = 2'b00;
      end
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign trapHit = ((sizeIn == SZ_HALF) && alu_result_in[0]) ||
                   ((sizeIn == SZ_WORD) && (alu_result_in[1:0] != 2'b00));
`else
  assign trapHit = 1'b0;
`endif

  load_extend u_load_extend (
    .rdata_i  (dmem.dmem_rdata),
    .offset_i (offset_q),
    .funct3_i (funct3_q),
    .data_o   (extData)
  );

  // Access sequencer. IDLE latches the op and starts the bus request (or,
  // for a trapped misaligned op, jumps straight to DONE). BUSY holds the
  // request until ack and captures load data. DONE is a single cycle in
  // which valid_in is ignored because EX/MEM still shows the finished op.
  // Pulses (load_valid, misalign) default low every cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      be_q        <= '0;
      offset_q    <= 2'b00;
      funct3_q    <= 3'b000;
      loadData_q  <= 32'h0;
      loadValid_q <= 1'b0;
      misalign_q  <= 1'b0;
    end else begin
      loadValid_q <= 1'b0;
      misalign_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (valid_in) begin
            if (trapHit) begin
              state_q    <= DONE;
              misalign_q <= 1'b1;
            end else begin
              state_q  <= BUSY;
              req_q    <= 1'b1;
              we_q     <= mem_rw_in;
              addr_q   <= addr_d;
              wdata_q  <= wdata_d;
              be_q     <= be_d;
              offset_q <= offset_d;
              funct3_q <= funct3In;
            end
          end
        end
        BUSY: begin
          if (dmem.dmem_ack) begin
            state_q <= DONE;
            req_q   <= 1'b0;
            if (!we_q) begin
              loadData_q  <= extData;
              loadValid_q <= 1'b1;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Bus outputs come straight from registers so they stay put while req is up.
  assign dmem.dmem_req   = req_q;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_wdata = wdata_q;
  assign dmem.dmem_be    = be_q;

  assign load_data_out  = loadData_q;
  assign load_valid_out = loadValid_q;
  assign misalign_out   = misalign_q;

  // Stall must rise in the same cycle the op shows up in IDLE so EX/MEM holds
  // it; reset keeps it low so nothing upstream freezes during reset.
  assign stall_out = !reset &&
                     (((state_q == IDLE) && valid_in) || (state_q == BUSY));

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu
// Directed self-checking bench for mem_stage_lsu. Expected load results are
// queued when a load is driven and popped when load_valid_out appears.
// Covers both builds of LSU_MISALIGN_TRAP_EN.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in;
  logic        mem_rw_in;
  logic [31:0] instruction_in;
  logic [31:0] alu_result_in;
  logic [31:0] store_data_in;
  logic [31:0] load_data_out;
  logic        load_valid_out;
  logic        stall_out;
  logic        misalign_out;

  int          checks = 0;
  int          failures = 0;
  int          cycleCount = 0;
  logic [31:0] expQ[$];

  mem_stage_lsu_if dmem();

  mem_stage_lsu dut (
    .clk            (clk),
    .reset          (reset),
    .valid_in       (valid_in),
    .mem_rw_in      (mem_rw_in),
    .instruction_in (instruction_in),
    .alu_result_in  (alu_result_in),
    .store_data_in  (store_data_in),
    .dmem           (dmem),
    .load_data_out  (load_data_out),
    .load_valid_out (load_valid_out),
    .stall_out      (stall_out),
    .misalign_out   (misalign_out)
  );

  // Free-running clock and cycle counter used for pulse spacing.
  always #5 clk = ~clk;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  // Safety net so the run always ends even if the flow gets stuck.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Drives one EX/MEM op at the next falling edge.
  task automatic applyStimulus(input logic vld, input logic rw, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] sdata);
    @(negedge clk);
    valid_in       = vld;
    mem_rw_in      = rw;
    instruction_in = {17'h0, f3, 5'd1, (rw ? 7'b0100011 : 7'b0000011)};
    alu_result_in  = addr;
    store_data_in  = sdata;
  endtask

  // Full access: IDLE cycle, BUSY cycles with 'waits' extra cycles before
  // ack, then the DONE cycle. Returns the cycle number of DONE.
  task automatic runAccess(input string tag, input logic rw, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] sdata,
                           input logic [31:0] rdata, input int waits,
                           input logic [31:0] expAddr, input logic [3:0] expBe,
                           input logic [31:0] expWdata, input logic [31:0] expLoad,
                           output int doneCycle);
    int stalls;
    logic [31:0] want;
    applyStimulus(1'b1, rw, f3, addr, sdata);
    if (!rw) expQ.push_back(expLoad);
    #1;
    stalls = stall_out ? 1 : 0;
    checkOutput({tag, "_idle_req"}, {31'b0, dmem.dmem_req}, 32'd0);
    for (int w = 0; w <= waits; w++) begin
      @(negedge clk);
      dmem.dmem_ack   = (w == waits);
      dmem.dmem_rdata = (w == waits) ? rdata : 32'h0BADF00D;
      #1;
      if (stall_out) stalls++;
      checkOutput({tag, "_req"}, {31'b0, dmem.dmem_req}, 32'd1);
      checkOutput({tag, "_we"}, {31'b0, dmem.dmem_we}, {31'b0, rw});
      checkOutput({tag, "_addr"}, dmem.dmem_addr, expAddr);
      checkOutput({tag, "_be"}, {28'b0, dmem.dmem_be}, {28'b0, expBe});
      if (rw) checkOutput({tag, "_wdata"}, dmem.dmem_wdata, expWdata);
    end
    @(negedge clk);
    dmem.dmem_ack   = 1'b0;
    dmem.dmem_rdata = 32'h0;
    #1;
    if (stall_out) stalls++;
    doneCycle = cycleCount;
    checkOutput({tag, "_done_req"}, {31'b0, dmem.dmem_req}, 32'd0);
    checkOutput({tag, "_stall_cycles"}, stalls, waits + 2);
    checkOutput({tag, "_misalign"}, {31'b0, misalign_out}, 32'd0);
    checkOutput({tag, "_load_valid"}, {31'b0, load_valid_out}, {31'b0, !rw});
    if (load_valid_out) begin
      if (expQ.size() == 0) begin
        checkOutput({tag, "_unexpected_load"}, 32'd1, 32'd0);
      end else begin
        want = expQ.pop_front();
        checkOutput({tag, "_load_data"}, load_data_out, want);
      end
    end
  endtask

  // Directed sequence.
  initial begin
    int d0;
    int d1;
    int d2;
    reset           = 1'b1;
    valid_in        = 1'b0;
    mem_rw_in       = 1'b0;
    instruction_in  = 32'h0;
    alu_result_in   = 32'h0;
    store_data_in   = 32'h0;
    dmem.dmem_ack   = 1'b0;
    dmem.dmem_rdata = 32'h0;

    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_req", {31'b0, dmem.dmem_req}, 32'd0);
    checkOutput("rst_we", {31'b0, dmem.dmem_we}, 32'd0);
    checkOutput("rst_addr", dmem.dmem_addr, 32'd0);
    checkOutput("rst_wdata", dmem.dmem_wdata, 32'd0);
    checkOutput("rst_be", {28'b0, dmem.dmem_be}, 32'd0);
    checkOutput("rst_load_data", load_data_out, 32'd0);
    checkOutput("rst_load_valid", {31'b0, load_valid_out}, 32'd0);
    checkOutput("rst_stall", {31'b0, stall_out}, 32'd0);
    checkOutput("rst_misalign", {31'b0, misalign_out}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Stores: word with two wait states, byte and half lane replication.
    runAccess("sw", 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 2,
              32'h100, 4'b1111, 32'hDEADBEEF, 32'h0, d0);
    runAccess("sb", 1'b1, 3'b000, 32'h103, 32'h000000A5, 32'h0, 0,
              32'h100, 4'b1000, 32'hA5A5A5A5, 32'h0, d0);
    runAccess("sh", 1'b1, 3'b001, 32'h102, 32'h1234BEEF, 32'h0, 1,
              32'h100, 4'b1100, 32'hBEEFBEEF, 32'h0, d0);

    // Loads: lane select plus sign/zero extension; LBU and LB back-to-back.
    runAccess("lb2", 1'b0, 3'b000, 32'h102, 32'h0, 32'h80770000, 0,
              32'h100, 4'b0100, 32'h0, 32'h00000077, d0);
    runAccess("lbu3", 1'b0, 3'b100, 32'h103, 32'h0, 32'h80770000, 0,
              32'h100, 4'b1000, 32'h0, 32'h00000080, d1);
    runAccess("lb3", 1'b0, 3'b000, 32'h103, 32'h0, 32'h80770000, 0,
              32'h100, 4'b1000, 32'h0, 32'hFFFFFF80, d2);
    checkOutput("b2b_spacing", d2 - d1, 32'd3);
    runAccess("lh2", 1'b0, 3'b001, 32'h102, 32'h0, 32'h80770000, 1,
              32'h100, 4'b1100, 32'h0, 32'hFFFF8077, d0);
    runAccess("lhu0", 1'b0, 3'b101, 32'h100, 32'h0, 32'h1234ABCD, 0,
              32'h100, 4'b0011, 32'h0, 32'h0000ABCD, d0);
    runAccess("lw", 1'b0, 3'b010, 32'h104, 32'h0, 32'hCAFEF00D, 1,
              32'h104, 4'b1111, 32'h0, 32'hCAFEF00D, d0);
    runAccess("l011", 1'b0, 3'b011, 32'h108, 32'h0, 32'h13579BDF, 0,
              32'h108, 4'b1111, 32'h0, 32'h13579BDF, d0);

`ifdef LSU_MISALIGN_TRAP_EN
    // Misaligned LH is trapped: one stall cycle, no bus request.
    applyStimulus(1'b1, 1'b0, 3'b001, 32'h201, 32'h0);
    #1;
    checkOutput("trap_idle_stall", {31'b0, stall_out}, 32'd1);
    @(negedge clk);
    #1;
    checkOutput("trap_req", {31'b0, dmem.dmem_req}, 32'd0);
    checkOutput("trap_stall", {31'b0, stall_out}, 32'd0);
    checkOutput("trap_misalign", {31'b0, misalign_out}, 32'd1);
    checkOutput("trap_load_valid", {31'b0, load_valid_out}, 32'd0);
    @(negedge clk);
    valid_in = 1'b0;
    #1;
    checkOutput("trap_misalign_clear", {31'b0, misalign_out}, 32'd0);
    checkOutput("trap_req_after", {31'b0, dmem.dmem_req}, 32'd0);
`else
    // Misaligned LH is forced down to the aligned halfword.
    runAccess("lh_mis", 1'b0, 3'b001, 32'h201, 32'h0, 32'h00008001, 0,
              32'h200, 4'b0011, 32'h0, 32'hFFFF8001, d0);
`endif

    // Reset while BUSY abandons the request; a late ack is ignored.
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h300, 32'h0);
    @(negedge clk);
    #1;
    checkOutput("rbusy_req", {31'b0, dmem.dmem_req}, 32'd1);
    reset    = 1'b1;
    valid_in = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("rbusy_req_after", {31'b0, dmem.dmem_req}, 32'd0);
    checkOutput("rbusy_stall_after", {31'b0, stall_out}, 32'd0);
    checkOutput("rbusy_load_valid", {31'b0, load_valid_out}, 32'd0);
    reset           = 1'b0;
    dmem.dmem_ack   = 1'b1;
    dmem.dmem_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    #1;
    checkOutput("late_ack_load_valid", {31'b0, load_valid_out}, 32'd0);
    checkOutput("late_ack_req", {31'b0, dmem.dmem_req}, 32'd0);
    checkOutput("late_ack_stall", {31'b0, stall_out}, 32'd0);
    dmem.dmem_ack   = 1'b0;
    dmem.dmem_rdata = 32'h0;
    @(negedge clk);
    #1;
    checkOutput("late_ack_load_valid2", {31'b0, load_valid_out}, 32'd0);
    checkOutput("late_ack_load_data", load_data_out, 32'd0);

    // Normal operation resumes from IDLE after reset.
    runAccess("sw_post", 1'b1, 3'b010, 32'h10C, 32'h01020304, 32'h0, 0,
              32'h10C, 4'b1111, 32'h01020304, 32'h0, d0);

    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    #1;
    checkOutput("idle_end_req", {31'b0, dmem.dmem_req}, 32'd0);
    checkOutput("queue_empty", expQ.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
